time_set_ctrl: RTL and testbench

//  Time-setting sequencer for the 24-hour clock. Consumes debounced one-cycle button pulses
//  (SELECT, INCREMENT) plus a debounced INCREMENT hold level. Walks the clock through
//  RUN -> SET_HOUR -> SET_MIN -> RUN and issues single-cycle increment strobes to the hour and

---
 rtl/time_set_ctrl_if.sv | 24 ++
 rtl/time_set_ctrl.sv | 148 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Button and control bus between the debounced front panel and the time-setting sequencer.
// The sequencer uses the slave modport; the stimulus/panel side uses the master modport.
interface time_set_ctrl_if;
  logic       enable_khz;
  logic       sel_pulse;
  logic       inc_pulse;
  logic       inc_held;
  logic [1:0] mode;
  logic       run_en;
  logic       hour_inc;
  logic       min_inc;
  logic       sec_clr;
  logic       blink;

  modport master (
    output enable_khz, sel_pulse, inc_pulse, inc_held,
    input  mode, run_en, hour_inc, min_inc, sec_clr, blink
  );

  modport slave (
    input  enable_khz, sel_pulse, inc_pulse, inc_held,
    output mode, run_en, hour_inc, min_inc, sec_clr, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: RUN -> SET_HOUR -> SET_MIN -> RUN, with increment strobes,
// auto-repeat while INCREMENT is held, inactivity timeout and a blink gate for the edited field.
module time_set_ctrl #(
  parameter int REPEAT_DLY_MS  = 500,
  parameter int REPEAT_RATE_MS = 100,
  parameter int TIMEOUT_MS     = 10000,
  parameter int BLINK_HALF_MS  = 250
) (
  input  logic           CLK,
  input  logic           RST,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  localparam int HOLD_W  = $clog2(REPEAT_DLY_MS + 1);
  localparam int RATE_W  = $clog2(REPEAT_RATE_MS + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_MS + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(REPEAT_DLY_MS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_DONE  = HOLD_W'(REPEAT_DLY_MS);
  localparam logic [RATE_W-1:0]  RATE_LAST  = RATE_W'(REPEAT_RATE_MS - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(TIMEOUT_MS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_MS - 1);

  mode_t               mode_reg;
  mode_t               mode_next;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [RATE_W-1:0]   rate_cnt_reg;
  logic [IDLE_W-1:0]   idle_cnt_reg;
  logic [BLINK_W-1:0]  blink_cnt_reg;
  logic                run_en_reg;
  logic                hour_inc_reg;
  logic                min_inc_reg;
  logic                sec_clr_reg;
  logic                blink_reg;

  logic in_set;
  logic timeout_hit;
  logic mode_change;
  logic repeat_fire;
  logic inc_fire;

  always_comb begin
    in_set      = (mode_reg != RUN);
    timeout_hit = in_set && (idle_cnt_reg == IDLE_LIMIT);
    mode_change = bus.sel_pulse || timeout_hit;
    // First repeat when the hold delay completes, then one per rate period once saturated.
    repeat_fire = in_set && bus.inc_held && bus.enable_khz &&
                  ((hold_cnt_reg == HOLD_LAST) ||
                   ((hold_cnt_reg == HOLD_DONE) && (rate_cnt_reg == RATE_LAST)));
    inc_fire    = in_set && !mode_change && (bus.inc_pulse || repeat_fire);

    mode_next = RUN;
    if (bus.sel_pulse) begin
      case (mode_reg)
        RUN:      mode_next = SET_HOUR;
        SET_HOUR: mode_next = SET_MIN;
        default:  mode_next = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_reg      <= RUN;
      hold_cnt_reg  <= '0;
      rate_cnt_reg  <= '0;
      idle_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      run_en_reg    <= 1'b1;
      hour_inc_reg  <= 1'b0;
      min_inc_reg   <= 1'b0;
      sec_clr_reg   <= 1'b0;
      blink_reg     <= 1'b1;
    end else begin
      hour_inc_reg <= 1'b0;
      min_inc_reg  <= 1'b0;
      sec_clr_reg  <= 1'b0;

      if (mode_change) begin
        // SELECT beats a coinciding timeout; only a SELECT out of SET_MIN clears seconds.
        mode_reg      <= mode_next;
        run_en_reg    <= (mode_next == RUN);
        sec_clr_reg   <= bus.sel_pulse && (mode_reg == SET_MIN);
        hold_cnt_reg  <= '0;
        rate_cnt_reg  <= '0;
        idle_cnt_reg  <= '0;
        blink_cnt_reg <= '0;
        blink_reg     <= 1'b1;
      end else if (in_set) begin
        hour_inc_reg <= inc_fire && (mode_reg == SET_HOUR);
        min_inc_reg  <= inc_fire && (mode_reg == SET_MIN);

        if (!bus.inc_held) begin
          hold_cnt_reg <= '0;
          rate_cnt_reg <= '0;
        end else if (bus.enable_khz) begin
          if (hold_cnt_reg != HOLD_DONE) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end else if (rate_cnt_reg == RATE_LAST) begin
            rate_cnt_reg <= '0;
          end else begin
            rate_cnt_reg <= rate_cnt_reg + 1'b1;
          end
        end

        if (bus.inc_pulse || bus.inc_held) begin
          idle_cnt_reg <= '0;
        end else if (bus.enable_khz) begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end

        if (inc_fire) begin
          blink_cnt_reg <= '0;
          blink_reg     <= 1'b1;
        end else if (bus.enable_khz) begin
          if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            blink_reg     <= !blink_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
          end
        end
      end else begin
        hold_cnt_reg  <= '0;
        rate_cnt_reg  <= '0;
        idle_cnt_reg  <= '0;
        blink_cnt_reg <= '0;
        blink_reg     <= 1'b1;
        run_en_reg    <= 1'b1;
      end
    end
  end

  assign bus.mode     = mode_reg;
  assign bus.run_en   = run_en_reg;
  assign bus.hour_inc = hour_inc_reg;
  assign bus.min_inc  = min_inc_reg;
  assign bus.sec_clr  = sec_clr_reg;
  assign bus.blink    = blink_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl; output vector is {mode[1:0], run_en, hour_inc, min_inc, sec_clr, blink}.
module tb_time_set_ctrl;

  localparam logic [6:0] RUNV  = 7'b00_1_0_0_0_1;
  localparam logic [6:0] RUNC  = 7'b00_1_0_0_1_1;
  localparam logic [6:0] HOURV = 7'b01_0_0_0_0_1;
  localparam logic [6:0] HOURI = 7'b01_0_1_0_0_1;
  localparam logic [6:0] MINV  = 7'b10_0_0_0_0_1;
  localparam logic [6:0] STRB  = 7'b00_0_1_1_1_0;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .REPEAT_DLY_MS (5),
    .REPEAT_RATE_MS(2),
    .TIMEOUT_MS    (20),
    .BLINK_HALF_MS (3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] ex(input logic [1:0] md, input logic h, input logic m,
                                    input logic s, input logic b);
    return {md, (md == 2'b00), h, m, s, b};
  endfunction

  task automatic chk(input logic [6:0] e, input string tag);
    logic [6:0] got;
    got = {bus.mode, bus.run_en, bus.hour_inc, bus.min_inc, bus.sec_clr, bus.blink};
    n_vec++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, e);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic cyc(input logic s, input logic i, input logic h, input logic t,
                     input logic [6:0] e, input string tag);
    bus.sel_pulse  = s;
    bus.inc_pulse  = i;
    bus.inc_held   = h;
    bus.enable_khz = t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    bus.sel_pulse  = 1'b0;
    bus.inc_pulse  = 1'b0;
    bus.enable_khz = 1'b0;
    chk(exp_q.pop_front(), tag_q.pop_front());
  endtask

  // One kHz tick followed by a quiet cycle; strobes must be gone in the quiet cycle.
  task automatic tk(input logic h, input logic [6:0] e, input string tag);
    cyc(1'b0, 1'b0, h, 1'b1, e, tag);
    cyc(1'b0, 1'b0, h, 1'b0, e & ~STRB, {tag, "_q"});
  endtask

  initial begin
    bus.sel_pulse  = 1'b0;
    bus.inc_pulse  = 1'b0;
    bus.inc_held   = 1'b0;
    bus.enable_khz = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk(RUNV, "reset_state");
    RST = 1'b0;

    // Full SELECT cycle with SEC_CLR on return to RUN
    cyc(1, 0, 0, 0, HOURV, "sel1");
    cyc(0, 0, 0, 0, HOURV, "sel1_hold");
    cyc(1, 0, 0, 0, MINV,  "sel2");
    cyc(0, 0, 0, 0, MINV,  "sel2_hold");
    cyc(1, 0, 0, 0, RUNC,  "sel3_secclr");
    cyc(0, 0, 0, 0, RUNV,  "sel3_after");

    // INCREMENT is ignored in RUN, pulses and holds alike
    cyc(0, 1, 0, 0, RUNV, "run_inc");
    cyc(0, 1, 1, 0, RUNV, "run_inc_held");
    for (int k = 1; k <= 6; k++) tk(1'b1, RUNV, $sformatf("run_held_k%0d", k));
    cyc(0, 0, 0, 0, RUNV, "run_release");

    // Two single hour strobes
    cyc(1, 0, 0, 0, HOURV, "to_hour");
    cyc(0, 1, 0, 0, HOURI, "hour_inc1");
    cyc(0, 0, 0, 0, HOURV, "hour_inc1_end");
    cyc(0, 1, 0, 0, HOURI, "hour_inc2");
    cyc(0, 0, 0, 0, HOURV, "hour_inc2_end");

    // Auto-repeat in SET_MIN: strobes after ticks 5,7,9,11; blink forced by each strobe
    cyc(1, 0, 0, 0, MINV, "to_min");
    for (int k = 1; k <= 11; k++) begin
      tk(1'b1, ex(2'b10, 1'b0, (k >= 5) && (k % 2 == 1), 1'b0, !(k == 3 || k == 4)),
         $sformatf("hold_k%0d", k));
    end
    for (int r = 1; r <= 4; r++) tk(1'b0, ex(2'b10, 0, 0, 0, r < 3), $sformatf("release_r%0d", r));
    cyc(1, 0, 0, 0, RUNC, "min_to_run");
    cyc(0, 0, 0, 0, RUNV, "min_to_run_after");

    // Inactivity timeout: RUN without SEC_CLR, blink toggling every 3 ticks meanwhile
    cyc(1, 0, 0, 0, HOURV, "to_hour_idle");
    for (int k = 1; k <= 19; k++) tk(1'b0, ex(2'b01, 0, 0, 0, (k / 3) % 2 == 0), $sformatf("idle_k%0d", k));
    cyc(0, 0, 0, 1, HOURV, "idle_k20");
    cyc(0, 0, 0, 0, RUNV,  "timeout_run");

    // SELECT on the timeout cycle takes the normal transition
    cyc(1, 0, 0, 0, HOURV, "to_hour_idle2");
    for (int k = 1; k <= 19; k++) tk(1'b0, ex(2'b01, 0, 0, 0, (k / 3) % 2 == 0), $sformatf("idle2_k%0d", k));
    cyc(0, 0, 0, 1, HOURV, "idle2_k20");
    cyc(1, 0, 0, 0, MINV,  "timeout_sel_wins");
    cyc(1, 0, 0, 0, RUNC,  "back_to_run");
    cyc(1, 0, 0, 0, HOURV, "to_hour_again");

    // SELECT and INCREMENT together: mode advances, no strobe
    cyc(1, 1, 0, 0, MINV, "sel_inc_same");
    cyc(0, 0, 0, 0, MINV, "sel_inc_after");
    cyc(1, 0, 0, 0, RUNC, "to_run2");
    cyc(1, 0, 0, 0, HOURV, "to_hour_blink");

    // Blink restart on an increment strobe
    for (int k = 1; k <= 3; k++) tk(1'b0, ex(2'b01, 0, 0, 0, k < 3), $sformatf("blink_a%0d", k));
    cyc(0, 1, 0, 0, HOURI, "blink_inc_forces");
    for (int k = 1; k <= 3; k++) tk(1'b0, ex(2'b01, 0, 0, 0, k < 3), $sformatf("blink_b%0d", k));

    // Asynchronous reset in the middle of SET_MIN with an INCREMENT pending
    cyc(1, 0, 0, 0, MINV, "to_min_rst");
    for (int k = 1; k <= 3; k++) tk(1'b0, ex(2'b10, 0, 0, 0, k < 3), $sformatf("rst_pre%0d", k));
    bus.inc_pulse = 1'b1;
    #2 RST = 1'b1;
    #1 chk(RUNV, "async_rst_now");
    @(posedge CLK);
    #1 chk(RUNV, "rst_held");
    RST = 1'b0;
    bus.inc_pulse = 1'b0;
    cyc(0, 0, 0, 0, RUNV, "rst_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
